pipeline_fetch: RTL and testbench
=================================

Name: pipeline_fetch

Overview:
Instruction fetch stage and the producer side of the decode stage's instruction/instruction_pc/ready interface. Holds the PC and issues 32-bit fetches to the instruction memory port, with at most one request outstanding. Buffers returned words in a 2-entry queue and presents them to decode. When the queue is empty it drives the bubble encoding (32'd90). Execute can redirect the PC on a taken branch or jump; the redirect flushes queued and in-flight fetches.

Parameters:
ADDR_WIDTH, 64, PC/address width
DATA_WIDTH, 64, datapath width; instruction width is DATA_WIDTH/2
RESET_PC, 0, first fetch address after reset
QUEUE_DEPTH, 2, fetch queue entries; power of two, ≥2

Ports:
clk  input  1  clock
reset  input  1  reset; asynchronous, active-low (0 = reset asserted)
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  ADDR_WIDTH  fetch address; bits [1:0] always 0
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response data valid (one per accepted request, in order, ≥1 cycle after acceptance)
imem_resp_data  input  DATA_WIDTH/2  fetched instruction word
redirect_valid  input  1  execute redirect strobe (single cycle)
redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored
decode_ready  input  1  decode consumes the presented instruction this cycle
instruction  output  DATA_WIDTH/2  to decode; 32'd90 when no valid entry
instruction_pc  output  ADDR_WIDTH  PC of the presented instruction; 0 with the bubble

Behaviour:
- Reset values (async on reset=0): pc=RESET_PC; queue empty; state=REQ; imem_req_valid=0; imem_req_addr=RESET_PC; instruction=32'd90; instruction_pc=0. imem_req_valid may rise no earlier than the first clk edge after reset deasserts.
- States:
  - REQ: imem_req_valid=1 if (count + outstanding) < QUEUE_DEPTH; imem_req_addr=pc. On req_valid && req_ready: pc+=4, go to WAIT.
  - WAIT: imem_req_valid=0. On resp_valid: push {pc_of_req, resp_data}, go to REQ.
  - DRAIN: imem_req_valid=0. On resp_valid: discard, go to REQ.
- The address of each outstanding request is held in a register. It is written to the queue with the response. Do not recompute it from pc.
- Decode side:
  - Head entry is presented combinationally from queue storage.
  - Pop when decode_ready && count≠0.
  - Response-to-decode latency is 1 cycle (push at edge N, visible after N).
  - No bypass of the queue.
- Push and pop in the same cycle: count is unchanged, and pointers wrap modulo QUEUE_DEPTH.
- Full queue: no request is issued, so a response never arrives into a full queue. If it does anyway, that is an assertion failure.
- Redirect (highest priority, same edge):
  - pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; queue cleared; the same-cycle pop and push are ignored.
  - Next state:
    - DRAIN if a request is outstanding (WAIT) or is accepted this same cycle;
    - REQ otherwise;
    - REQ if resp_valid arrives in the same cycle in WAIT (that response is dropped).
  - New request for the target is visible the cycle after the redirect.
- Redirect while in DRAIN: update pc, stay in DRAIN.
- pc wraps modulo 2^ADDR_WIDTH.
- A response of 32'd90 is queued like any other word.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched (64-bit, count of queue pushes), perf_bubbles (64-bit, cycles with count==0 presented to decode), and perf_flushes (32-bit, count of redirects). All reset to 0 and wrap on overflow.
- Undefined: these ports and counters do not exist; everything else is identical.

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSN = 32'd90 (also used by decode);
  - enum fetch_state_t {REQ, WAIT, DRAIN};
  - typedef fetch_entry_t {pc, insn}.
- Sub-module fetch_queue: parameterised FIFO with push/pop/flush/count, async active-low reset.
- The FSM and PC logic stay in pipeline_fetch.

Test Plan:
- Reset release, memory always ready with 1-cycle response, decode_ready=1 → addresses 0,4,8,…; decode sees pc 0 at cycle 3, then one instruction every 2 cycles; bubble 32'd90 between.
- decode_ready=0 for 10 cycles → exactly 2 words queued, then imem_req_valid stays 0. Release → pcs 0,4 presented in order, then fetching resumes at 8.
- Redirect to 0x1003 while in WAIT, response arrives 3 cycles later → response dropped, next request addr 0x1000, queue empty meanwhile, first presented pc 0x1000.
- Redirect in the same cycle as resp_valid and a pop → queue empty next cycle, state REQ, request 0x2000 issued next cycle, no stale instruction reaches decode.
- reset asserted mid-WAIT with 1 entry queued → outputs immediately 90/0, req_valid 0; after release the first request is RESET_PC.
- With FETCH_PERF_EN: run scenario 1 for 20 cycles with one redirect → perf counters match the scoreboard counts exactly.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: decode bubble encoding, fetch FSM states and
// the fetch queue entry layout (at the default 64-bit address / 32-bit insn widths).
package pipeline_pkg;

  localparam logic [31:0] NOP_INSN = 32'd90;

  localparam int unsigned FETCH_ADDR_W = 64;
  localparam int unsigned FETCH_INSN_W = 32;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/pipeline_fetch_queue.sv
// Power-of-two FIFO between the fetch FSM and decode; flush beats push/pop.
// Head entry is read combinationally from storage.
module fetch_queue #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: PC + REQ/WAIT/DRAIN FSM, one outstanding imem request,
// queue to decode. Optional FETCH_PERF_EN adds fetch/bubble/flush counters.
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 64,
  parameter int unsigned            DATA_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned            QUEUE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req_valid,
  output logic [ADDR_WIDTH-1:0]     imem_req_addr,
  input  logic                      imem_req_ready,
  input  logic                      imem_resp_valid,
  input  logic [DATA_WIDTH/2-1:0]   imem_resp_data,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  input  logic                      decode_ready,
  output logic [DATA_WIDTH/2-1:0]   instruction,
  output logic [ADDR_WIDTH-1:0]     instruction_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]               perf_fetched,
  output logic [63:0]               perf_bubbles,
  output logic [31:0]               perf_flushes
`endif
);

  localparam int unsigned INSN_W = DATA_WIDTH / 2;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INSN_W-1:0]     insn;
  } entry_t;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  started;
  logic [CNT_W-1:0]      q_count;
  entry_t                q_head;
  entry_t                q_push_data;
  logic                  req_fire;
  logic                  q_push;
  logic                  q_pop;
  logic                  q_empty;
  logic                  unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign req_fire    = imem_req_valid && imem_req_ready;
  assign q_empty     = (q_count == '0);
  assign q_push      = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign q_pop       = decode_ready && !q_empty && !redirect_valid;
  assign q_push_data = {req_pc, imem_resp_data};

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= state_next;
  end

  // A response always retires the outstanding request, even alongside a
  // redirect, so DRAIN/WAIT return to REQ whenever resp_valid is seen.
  always_comb begin
    state_next = state;
    unique case (state)
      REQ:
        if (redirect_valid) state_next = req_fire ? DRAIN : REQ;
        else if (req_fire)  state_next = WAIT;
      WAIT:
        if (imem_resp_valid)     state_next = REQ;
        else if (redirect_valid) state_next = DRAIN;
      DRAIN:
        if (imem_resp_valid) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = started && (state == REQ) && (q_count < CNT_W'(QUEUE_DEPTH));
    imem_req_addr  = pc;
    instruction    = q_empty ? INSN_W'(NOP_INSN) : q_head.insn;
    instruction_pc = q_empty ? '0 : q_head.pc;
  end

  // started holds off the first request until one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC_ALIGNED;
      req_pc  <= RESET_PC_ALIGNED;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (req_fire)  pc <= pc + ADDR_WIDTH'(4);
      if (req_fire) req_pc <= pc;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    (state == WAIT && imem_resp_valid) |-> (q_count < CNT_W'(QUEUE_DEPTH)));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (q_push)         perf_fetched <= perf_fetched + 64'd1;
      if (q_empty)        perf_bubbles <= perf_bubbles + 64'd1;
      if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: vector table, corner sequences and a
// randomized run against a transaction-level model (FETCH_PERF_EN optional).
module tb_pipeline_fetch;
  import pipeline_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        decode_ready;
  logic [31:0] instruction;
  logic [63:0] instruction_pc;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  pipeline_fetch #(
    .ADDR_WIDTH  (64),
    .DATA_WIDTH  (64),
    .RESET_PC    (64'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .decode_ready    (decode_ready),
    .instruction     (instruction),
    .instruction_pc  (instruction_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles),
    .perf_flushes    (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; decode_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_insn", instruction, NOP_INSN);
    chk("rst_insn_pc", instruction_pc, 0);
`ifdef FETCH_PERF_EN
    chk("rst_perf", perf_fetched | perf_bubbles | 64'(perf_flushes), 0);
`endif
    reset = 1'b1; #1;
    chk("rel_req_valid", imem_req_valid, 0);
  endtask

  task automatic cyc(input bit rdy, input bit rv, input logic [31:0] d, input bit dr,
                     input bit rd, input logic [63:0] rpc);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = d;
    decode_ready = dr; redirect_valid = rd; redirect_pc = rpc;
    @(posedge clk); #1;
  endtask

  task automatic chk4(input string tag, input bit erv, input logic [63:0] ea,
                      input logic [31:0] ei, input logic [63:0] ep);
    chk({tag, "_req_valid"}, imem_req_valid, erv);
    chk({tag, "_req_addr"}, imem_req_addr, ea);
    chk({tag, "_insn"}, instruction, ei);
    chk({tag, "_insn_pc"}, instruction_pc, ep);
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] d;
    bit          dr;
    bit          rd;
    logic [63:0] rpc;
    bit          e_rv;
    logic [63:0] e_addr;
    logic [31:0] e_insn;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [31:0] d, bit dr, bit rd,
                              logic [63:0] rpc, bit erv, logic [63:0] ea,
                              logic [31:0] ei, logic [63:0] ep);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.d = d; v.dr = dr; v.rd = rd; v.rpc = rpc;
    v.e_rv = erv; v.e_addr = ea; v.e_insn = ei; v.e_pc = ep;
    return v;
  endfunction

  // Transaction-level reference: PC, list of queued {pc,insn}, one pending fetch
  // that may be marked as discarded by a redirect.
  logic [63:0]  m_pc;
  fetch_entry_t m_q[$];
  bit           m_out;
  bit           m_disc;
  logic [63:0]  m_out_addr;
  bit           m_started;
  logic [63:0]  sc_fetched;
  logic [63:0]  sc_bubbles;
  logic [31:0]  sc_flushes;

  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a[5:2] == 4'd7) return NOP_INSN;
    return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic model_edge(input bit rv_pred);
    fetch_entry_t tmp;
    bit acc;
    acc = rv_pred && imem_req_ready;
    if (m_q.size() == 0) sc_bubbles++;
    if (redirect_valid) begin
      sc_flushes++;
      m_q.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
      if (m_out && imem_resp_valid) m_out = 1'b0;
      else if (m_out)               m_disc = 1'b1;
      else if (acc) begin m_out = 1'b1; m_disc = 1'b1; end
    end else begin
      if (decode_ready && m_q.size() != 0) tmp = m_q.pop_front();
      if (m_out && imem_resp_valid) begin
        if (!m_disc) begin
          m_q.push_back('{pc: m_out_addr, insn: imem_resp_data});
          sc_fetched++;
        end
        m_out = 1'b0;
      end
      if (acc) begin
        m_out = 1'b1; m_disc = 1'b0; m_out_addr = m_pc; m_pc = m_pc + 64'd4;
      end
    end
    m_started = 1'b1;
  endtask

  bit          e_rv;
  bit          prev_acc;
  bit          prev_resp;
  logic [63:0] prev_addr;
  bit          mem_pend;
  int          mem_wait;
  logic [63:0] mem_addr;
  logic [31:0] r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: rst rdy rv data dr rd rpc | req_valid req_addr insn insn_pc
    // Free-running fetch, 1-cycle memory; a 90 word is queued as data.
    tbl.push_back(mk(1, 1, 0, 0,            1, 0, 0, 1, 0,  NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0, 0, 4,  NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE0000, 1, 0, 0, 1, 4,  32'hC0DE0000, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0, 0, 8,  NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 1, 32'd90,       1, 0, 0, 1, 8,  32'd90,       4));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0, 0, 12, NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE0008, 1, 0, 0, 1, 12, 32'hC0DE0008, 8));
    // Decode stalled 10 cycles: queue fills, requests stop, then resume at 8.
    tbl.push_back(mk(1, 1, 0, 0,            0, 0, 0, 1, 0,  NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0, 0, 4,  NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE0000, 0, 0, 0, 1, 4,  32'hC0DE0000, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0, 0, 8,  32'hC0DE0000, 0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE0004, 0, 0, 0, 0, 8,  32'hC0DE0000, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, 0, 0,          0, 0, 0, 0, 8,  32'hC0DE0000, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0, 1, 8,  32'hC0DE0004, 4));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0, 0, 12, NOP_INSN,     0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE0008, 1, 0, 0, 1, 12, 32'hC0DE0008, 8));
    // Redirect to 0x1003 in WAIT; stale response three cycles later is dropped.
    tbl.push_back(mk(1, 1, 0, 0,            1, 0, 0,         1, 0,         NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,         0, 4,         NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 1, 64'h1003,  0, 64'h1000,  NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,         0, 64'h1000,  NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,         0, 64'h1000,  NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 1, 32'hDEADBEEF, 1, 0, 0,         1, 64'h1000,  NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,         0, 64'h1004,  NOP_INSN, 0));
    tbl.push_back(mk(0, 1, 1, 32'hC0DE1000, 1, 0, 0,         1, 64'h1004,  32'hC0DE1000, 64'h1000));

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      cyc(tbl[i].rdy, tbl[i].rv, tbl[i].d, tbl[i].dr, tbl[i].rd, tbl[i].rpc);
      chk4($sformatf("tbl%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_insn, tbl[i].e_pc);
    end

    // Redirect coincident with a response in WAIT and a pop.
    apply_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hC0DE0000, 0, 0, 0);
    chk("s4_queued", instruction, 32'hC0DE0000);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s4_wait_addr", imem_req_addr, 8);
    cyc(0, 1, 32'hC0DE0004, 1, 1, 64'h2000);
    chk4("s4_flush", 1, 64'h2000, NOP_INSN, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk4("s4_hold", 1, 64'h2000, NOP_INSN, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk4("s4_acc", 0, 64'h2004, NOP_INSN, 0);
    cyc(1, 1, 32'hC0DE2000, 1, 0, 0);
    chk4("s4_first", 1, 64'h2004, 32'hC0DE2000, 64'h2000);

    // Asynchronous reset while WAIT with one entry queued.
    apply_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hC0DE0000, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s5_pre_insn", instruction, 32'hC0DE0000);
    reset = 1'b0; #1;
    chk4("s5_async", 0, 0, NOP_INSN, 0);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    cyc(1, 0, 0, 0, 0, 0);
    chk4("s5_restart", 1, 0, NOP_INSN, 0);

    // Randomized run against the reference model.
    apply_reset();
    m_pc = '0; m_q.delete(); m_out = 1'b0; m_disc = 1'b0; m_started = 1'b0;
    sc_fetched = '0; sc_bubbles = '0; sc_flushes = '0;
    mem_pend = 1'b0; mem_wait = 0; prev_acc = 1'b0; prev_resp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      e_rv = m_started && !m_out && (m_q.size() < 2);
      chk("rnd_req_valid", imem_req_valid, e_rv);
      chk("rnd_req_addr", imem_req_addr, m_pc);
      chk("rnd_insn", instruction, (m_q.size() != 0) ? m_q[0].insn : NOP_INSN);
      chk("rnd_insn_pc", instruction_pc, (m_q.size() != 0) ? m_q[0].pc : 64'd0);

      if (prev_resp) mem_pend = 1'b0;
      if (prev_acc) begin
        mem_pend = 1'b1; mem_wait = $urandom_range(0, 2); mem_addr = prev_addr;
      end
      if (mem_pend && mem_wait == 0) begin
        imem_resp_valid = 1'b1; imem_resp_data = memf(mem_addr);
      end else begin
        imem_resp_valid = 1'b0; imem_resp_data = $urandom;
        if (mem_pend) mem_wait--;
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      decode_ready   = ($urandom_range(0, 4) < 3);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom;
      redirect_pc = ($urandom_range(0, 3) == 0) ? {60'hFFFF_FFFF_FFFF_FFF, r[3:0]}
                                                : {$urandom, r};
      prev_acc  = imem_req_valid && imem_req_ready;
      prev_addr = imem_req_addr;
      prev_resp = imem_resp_valid;
      @(posedge clk);
      model_edge(e_rv);
      #1;
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, sc_fetched);
    chk("perf_bubbles", perf_bubbles, sc_bubbles);
    chk("perf_flushes", perf_flushes, sc_flushes);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
